// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/hazard_div_seq.sv
// Multi-cycle divide sequencer: holds a divide in E for a fixed number of
// compute cycles. An exception returns it to IDLE.
module hazard_div_seq
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic divStart,
    input  logic exc,
    input  logic memWait,
    output logic busy,
    output logic done,
    output logic divStall
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    div_state_t       state;
    div_state_t       nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;

    // Next-state and counter update. The counter keeps running during a memory
    // wait. Only DONE is held by a memory wait.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        if (exc) begin
            nextState = IDLE;
            nextCnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (divStart) begin
                        nextState = RUN;
                        nextCnt   = CNT_LOAD;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        nextState = DONE;
                    end else begin
                        nextCnt = cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!memWait) begin
                        nextState = IDLE;
                    end
                end
                default: begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end
            endcase
        end
    end

    // State, counter and the registered busy/done flags. Reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            busy  <= (nextState != IDLE);
            done  <= (nextState == DONE);
        end
    end

    assign divStall = ((state == IDLE) && divStart) || (state == RUN);

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller for the 5-stage MIPS core. It generates the
// forwarding selects, the interlocks and the per-stage stall and flush signals.
module hazard_ctl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_readyF,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              hiloreadE,
    input  logic              div_startE,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        forwardhiloE,
    output logic              div_doneE,
    output logic              div_busy,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              hilowriteM,
    input  logic              mem_reqM,
    input  logic              mem_readyM,
    input  logic              excM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              hilowriteW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM
);

    logic memWait;
    logic lwStall;
    logic brStall;
    logic divStall;
    logic fWait;
    logic useRt;
    logic hitE;
    logic hitM;

    // Register 0 is hardwired zero and is never forwarded. M is newer than W, so M wins.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dstM,
        input logic              wrM,
        input logic [REG_AW-1:0] dstW,
        input logic              wrW
    );
        if ((src != '0) && wrM && (src == dstM)) begin
            return FWD_M;
        end else if ((src != '0) && wrW && (src == dstW)) begin
            return FWD_W;
        end
        return FWD_NONE;
    endfunction

    assign forwardaD = fwdSel(rsD, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardbD = fwdSel(rtD, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardaE = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardbE = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardhiloE = (hiloreadE && hilowriteM) ? FWD_M :
                          (hiloreadE && hilowriteW) ? FWD_W : FWD_NONE;

    assign memWait = mem_reqM && !mem_readyM;
    assign fWait   = !inst_readyF;
    assign lwStall = memtoregE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));

    // jr reads only rs. A branch compares rs and rt.
    assign useRt   = branchD;
    assign hitE    = regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (useRt && (writeregE == rtD)));
    assign hitM    = memtoregM && (writeregM != '0) &&
                     ((writeregM == rsD) || (useRt && (writeregM == rtD)));
    assign brStall = (branchD || jrD) && (hitE || hitM);

    hazard_div_seq #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) divSeq (
        .clk     (clk),
        .rst     (rst),
        .divStart(div_startE),
        .exc     (excM),
        .memWait (memWait),
        .busy    (div_busy),
        .done    (div_doneE),
        .divStall(divStall)
    );

    // Resolve stalls and flushes by fixed priority. The first active hazard decides.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (memWait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
        end else if (divStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwStall || brStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (fWait) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl. The first part applies a table of single-cycle
// vectors. Hand-written sequences then cover the multi-cycle divide, memory
// wait, exception and reset cases.
module tb_hazard_ctl;

    typedef struct {
        logic       instReady;
        logic [4:0] rsD, rtD;
        logic       branch, jr;
        logic [4:0] rsE, rtE, wrE;
        logic       regwE, memtoregE, hiloRead, divStart;
        logic [4:0] wrM;
        logic       regwM, memtoregM, hilowM, memReq, memReady, exc;
        logic [4:0] wrW;
        logic       regwW, hilowW;
    } inVec_t;

    typedef struct {
        logic [1:0] fwdAD, fwdBD, fwdAE, fwdBE, fwdHilo;
        logic [4:0] stall;
        logic [2:0] flush;
        logic       busy, done;
    } outVec_t;

    typedef struct {
        inVec_t  stim;
        outVec_t exp;
    } vector_t;

    logic       clk;
    logic       rst;
    logic       inst_readyF;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, jrD, regwriteE, memtoregE, hiloreadE, div_startE;
    logic       regwriteM, memtoregM, hilowriteM, mem_reqM, mem_readyM, excM;
    logic       regwriteW, hilowriteW;
    logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE, forwardhiloE;
    logic       div_doneE, div_busy;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushD, flushE, flushM;

    int testsRun = 0;
    int testsFailed = 0;
    vector_t vecs[$];

    hazard_ctl #(
        .REG_AW    (5),
        .DIV_CYCLES(4),
        .CNT_W     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_readyF (inst_readyF),
        .rsD         (rsD),
        .rtD         (rtD),
        .branchD     (branchD),
        .jrD         (jrD),
        .forwardaD   (forwardaD),
        .forwardbD   (forwardbD),
        .rsE         (rsE),
        .rtE         (rtE),
        .writeregE   (writeregE),
        .regwriteE   (regwriteE),
        .memtoregE   (memtoregE),
        .hiloreadE   (hiloreadE),
        .div_startE  (div_startE),
        .forwardaE   (forwardaE),
        .forwardbE   (forwardbE),
        .forwardhiloE(forwardhiloE),
        .div_doneE   (div_doneE),
        .div_busy    (div_busy),
        .writeregM   (writeregM),
        .regwriteM   (regwriteM),
        .memtoregM   (memtoregM),
        .hilowriteM  (hilowriteM),
        .mem_reqM    (mem_reqM),
        .mem_readyM  (mem_readyM),
        .excM        (excM),
        .writeregW   (writeregW),
        .regwriteW   (regwriteW),
        .hilowriteW  (hilowriteW),
        .stallF      (stallF),
        .stallD      (stallD),
        .stallE      (stallE),
        .stallM      (stallM),
        .stallW      (stallW),
        .flushD      (flushD),
        .flushE      (flushE),
        .flushM      (flushM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic inVec_t idleIn();
        inVec_t v;
        v = '{default: '0};
        v.instReady = 1'b1;
        return v;
    endfunction

    function automatic outVec_t idleOut();
        outVec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic applyStimulus(input inVec_t v);
        inst_readyF = v.instReady;
        rsD = v.rsD;
        rtD = v.rtD;
        branchD = v.branch;
        jrD = v.jr;
        rsE = v.rsE;
        rtE = v.rtE;
        writeregE = v.wrE;
        regwriteE = v.regwE;
        memtoregE = v.memtoregE;
        hiloreadE = v.hiloRead;
        div_startE = v.divStart;
        writeregM = v.wrM;
        regwriteM = v.regwM;
        memtoregM = v.memtoregM;
        hilowriteM = v.hilowM;
        mem_reqM = v.memReq;
        mem_readyM = v.memReady;
        excM = v.exc;
        writeregW = v.wrW;
        regwriteW = v.regwW;
        hilowriteW = v.hilowW;
    endtask

    task automatic checkField(input string name, input logic [4:0] act, input logic [4:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input outVec_t e);
        checkField({tag, " fwdAD"}, {3'b0, forwardaD}, {3'b0, e.fwdAD});
        checkField({tag, " fwdBD"}, {3'b0, forwardbD}, {3'b0, e.fwdBD});
        checkField({tag, " fwdAE"}, {3'b0, forwardaE}, {3'b0, e.fwdAE});
        checkField({tag, " fwdBE"}, {3'b0, forwardbE}, {3'b0, e.fwdBE});
        checkField({tag, " fwdHilo"}, {3'b0, forwardhiloE}, {3'b0, e.fwdHilo});
        checkField({tag, " stall FDEMW"}, {stallF, stallD, stallE, stallM, stallW}, e.stall);
        checkField({tag, " flush DEM"}, {2'b0, flushD, flushE, flushM}, {2'b0, e.flush});
        checkField({tag, " busy"}, {4'b0, div_busy}, {4'b0, e.busy});
        checkField({tag, " done"}, {4'b0, div_doneE}, {4'b0, e.done});
    endtask

    // One clock cycle: drive after the falling edge, then check mid low phase.
    task automatic cycle(input string tag, input inVec_t v, input outVec_t e);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput(tag, e);
    endtask

    task automatic addVec(input inVec_t vi, input outVec_t vo);
        vector_t v;
        v.stim = vi;
        v.exp = vo;
        vecs.push_back(v);
    endtask

    initial begin
        inVec_t vi;
        outVec_t eo;

        // Combinational vectors. The sequencer stays IDLE throughout.
        vi = idleIn(); eo = idleOut();
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.instReady = 0; eo.stall = 5'b10000; eo.flush = 3'b100;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.memtoregE = 1; vi.wrE = 8; vi.rsD = 8; eo.stall = 5'b11000; eo.flush = 3'b010;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.memtoregE = 1; vi.wrE = 8; vi.rtD = 8; eo.stall = 5'b11000; eo.flush = 3'b010;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.memtoregE = 1; vi.wrE = 0; vi.rsD = 0;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.rsE = 8; vi.wrM = 8; vi.regwM = 1; eo.fwdAE = 2'b10;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.rtE = 5; vi.wrM = 5; vi.regwM = 1; vi.wrW = 5; vi.regwW = 1; eo.fwdBE = 2'b10;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.rsE = 3; vi.rtE = 3; vi.wrW = 3; vi.regwW = 1; eo.fwdAE = 2'b01; eo.fwdBE = 2'b01;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.rsE = 3; vi.wrM = 3; vi.regwM = 0;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.rsE = 0; vi.rsD = 0; vi.wrM = 0; vi.regwM = 1; vi.wrW = 0; vi.regwW = 1;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.rsD = 9; vi.rtD = 4; vi.wrM = 9; vi.regwM = 1; vi.wrW = 4; vi.regwW = 1;
        eo.fwdAD = 2'b10; eo.fwdBD = 2'b01;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.hiloRead = 1; vi.hilowM = 1; vi.hilowW = 1; eo.fwdHilo = 2'b10;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.hiloRead = 1; vi.hilowW = 1; eo.fwdHilo = 2'b01;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.hiloRead = 0; vi.hilowM = 1;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 9; vi.rtD = 2; vi.wrE = 9; vi.regwE = 1;
        eo.stall = 5'b11000; eo.flush = 3'b010;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 0; vi.rtD = 2; vi.wrE = 9; vi.regwE = 1;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.jr = 1; vi.rsD = 2; vi.rtD = 9; vi.wrE = 9; vi.regwE = 1;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 1; vi.rtD = 7; vi.wrM = 7; vi.memtoregM = 1;
        eo.stall = 5'b11000; eo.flush = 3'b010;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.memReq = 1; vi.memReady = 0; eo.stall = 5'b11111;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.memReq = 1; vi.memReady = 1;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.memReq = 1; vi.instReady = 0; vi.memtoregE = 1; vi.wrE = 6; vi.rsD = 6;
        eo.stall = 5'b11111;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.exc = 1; vi.memReq = 1; vi.instReady = 0; vi.divStart = 1;
        eo.flush = 3'b111;
        addVec(vi, eo);
        vi = idleIn(); eo = idleOut(); vi.instReady = 0; vi.memtoregE = 1; vi.wrE = 6; vi.rtD = 6;
        eo.stall = 5'b11000; eo.flush = 3'b010;
        addVec(vi, eo);

        // Reset state.
        rst = 1'b0;
        applyStimulus(idleIn());
        #3;
        checkOutput("reset", idleOut());
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cycle($sformatf("vec%0d", i), vecs[i].stim, vecs[i].exp);
        end

        // Load-use: one stall cycle, then M forwarding into E.
        vi = idleIn(); eo = idleOut(); vi.memtoregE = 1; vi.regwE = 1; vi.wrE = 8; vi.rsD = 8;
        eo.stall = 5'b11000; eo.flush = 3'b010;
        cycle("lduse c1", vi, eo);
        vi = idleIn(); eo = idleOut(); vi.rsE = 8; vi.wrM = 8; vi.regwM = 1; vi.memtoregM = 1; eo.fwdAE = 2'b10;
        cycle("lduse c2", vi, eo);

        // Branch on an ALU result: one stall cycle, then M forwarding into D.
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 9; vi.rtD = 3; vi.wrE = 9; vi.regwE = 1;
        eo.stall = 5'b11000; eo.flush = 3'b010;
        cycle("br c1", vi, eo);
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 9; vi.rtD = 3; vi.wrM = 9; vi.regwM = 1;
        eo.fwdAD = 2'b10;
        cycle("br c2", vi, eo);

        // Branch after a load: two stall cycles, then W forwarding into D.
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 9; vi.rtD = 3; vi.wrE = 9; vi.regwE = 1; vi.memtoregE = 1;
        eo.stall = 5'b11000; eo.flush = 3'b010;
        cycle("brld c1", vi, eo);
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 9; vi.rtD = 3; vi.wrM = 9; vi.regwM = 1; vi.memtoregM = 1;
        eo.stall = 5'b11000; eo.flush = 3'b010; eo.fwdAD = 2'b10;
        cycle("brld c2", vi, eo);
        vi = idleIn(); eo = idleOut(); vi.branch = 1; vi.rsD = 9; vi.rtD = 3; vi.wrW = 9; vi.regwW = 1;
        eo.fwdAD = 2'b01;
        cycle("brld c3", vi, eo);

        // Two back-to-back divides. The second one is aborted by an exception in RUN at cnt=2.
        vi = idleIn(); vi.divStart = 1;
        for (int k = 0; k < 8; k++) begin
            int p;
            p = (k < 6) ? k : k - 6;
            eo = idleOut();
            eo.stall = (p <= 4) ? 5'b11100 : 5'b00000;
            eo.flush = (p <= 4) ? 3'b001 : 3'b000;
            eo.busy = (p >= 1);
            eo.done = (p == 5);
            cycle($sformatf("div k%0d", k), vi, eo);
        end
        vi = idleIn(); vi.divStart = 1; vi.exc = 1;
        eo = idleOut(); eo.flush = 3'b111; eo.busy = 1;
        cycle("div exc", vi, eo);
        cycle("div after exc", idleIn(), idleOut());

        // A memory wait during RUN: the count keeps running, and DONE is held until ready.
        for (int k = 0; k < 9; k++) begin
            vi = idleIn(); eo = idleOut();
            vi.divStart = (k < 8);
            vi.memReq = (k >= 2 && k <= 7);
            vi.memReady = (k == 7);
            if (k < 2) begin
                eo.stall = 5'b11100; eo.flush = 3'b001;
            end else if (k <= 6) begin
                eo.stall = 5'b11111;
            end
            eo.busy = (k >= 1 && k <= 7);
            eo.done = (k >= 5 && k <= 7);
            cycle($sformatf("memwait k%0d", k), vi, eo);
        end

        // Reset pulled low in mid-RUN takes effect without waiting for a clock edge.
        vi = idleIn(); vi.divStart = 1;
        eo = idleOut(); eo.stall = 5'b11100; eo.flush = 3'b001;
        cycle("rst k0", vi, eo);
        eo.busy = 1;
        cycle("rst k1", vi, eo);
        @(negedge clk);
        applyStimulus(idleIn());
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst async", idleOut());
        @(negedge clk);
        rst = 1'b1;
        cycle("rst post1", idleIn(), idleOut());
        cycle("rst post2", idleIn(), idleOut());

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
